// File: rtl/sap2_computer.sv
// sap2_computer: SAP-2 style 8-bit machine with a multi-cycle CPU, program ROM and data RAM
package arch_defs_pkg;
  localparam logic [7:0] NOP   = 8'h00;
  localparam logic [7:0] HLT   = 8'h01;
  localparam logic [7:0] LDI_A = 8'h10;
  localparam logic [7:0] LDI_B = 8'h11;
  localparam logic [7:0] ADD_B = 8'h20;
  localparam logic [7:0] SUB_B = 8'h21;
  localparam logic [7:0] CMP_B = 8'h22;
endpackage

module sap2_rom #(
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     rd,
  input  logic [$clog2(DEPTH)-1:0] addr,
  output logic [7:0]               q
);
  logic [7:0] mem [DEPTH];
  // synchronous read, one cycle after the address phase
  always_ff @(posedge clk)
    if (rd) q <= mem[addr];
`ifndef SYNTHESIS
  task automatic init_sim_rom();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
  endtask
  task automatic dump();
    for (int i = 0; i < DEPTH; i++)
      if (mem[i] != 8'h00) $display("rom[%03h] = %02h", i, mem[i]);
  endtask
`endif
endmodule

module sap2_ram #(
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     rd,
  input  logic [$clog2(DEPTH)-1:0] addr,
  output logic [7:0]               q
);
  logic [7:0] mem [DEPTH];
  // read-only view; nothing in the current instruction set writes RAM
  always_ff @(posedge clk)
    if (rd) q <= mem[addr];
`ifndef SYNTHESIS
  task automatic init_sim_ram();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
  endtask
`endif
endmodule

module sap2_cpu
  import arch_defs_pkg::*;
#(
  parameter logic [15:0] ROM_BASE = 16'hF000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data,
  output logic [15:0] addr,
  output logic        rd,
  output logic        halt,
  output logic        flag_zero_o,
  output logic        flag_negative_o,
  output logic        flag_carry_o
);
  typedef enum logic [3:0] {
    S_FETCH_ADDR, S_FETCH_DATA, S_FETCH_LATCH, S_CHK_MORE_BYTES,
    S_OP_ADDR, S_OP_DATA, S_OP_LATCH, S_OP_DONE,
    S_EXEC, S_LATCH, S_HALT
  } state_t;
  state_t state, nxt;
  logic [15:0] counter_out;
  logic [7:0] opcode, a_out, b_out, temp_1_out, opnd;
  logic [8:0] res;
  logic step, is_ldi, is_alu, is_sub;
  assign is_ldi = opcode == LDI_A || opcode == LDI_B;
  assign is_sub = opcode == SUB_B || opcode == CMP_B;
  assign is_alu = is_sub || opcode == ADD_B;
  assign addr = counter_out;
  assign rd = state == S_FETCH_ADDR || state == S_OP_ADDR;
  assign halt = state == S_HALT;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_FETCH_ADDR;
    else state <= nxt;
  // sequencing: fetch, optional immediate fetch, execute microsteps, write-back
  always_comb begin
    nxt = state;
    case (state)
      S_FETCH_ADDR:     nxt = S_FETCH_DATA;
      S_FETCH_DATA:     nxt = S_FETCH_LATCH;
      S_FETCH_LATCH:    nxt = S_CHK_MORE_BYTES;
      S_CHK_MORE_BYTES: nxt = opcode == HLT ? S_HALT : is_ldi ? S_OP_ADDR : S_EXEC;
      S_OP_ADDR:        nxt = S_OP_DATA;
      S_OP_DATA:        nxt = S_OP_LATCH;
      S_OP_LATCH:       nxt = S_OP_DONE;
      S_OP_DONE:        nxt = S_EXEC;
      S_EXEC:           nxt = is_alu && !step ? S_EXEC : S_LATCH;
      S_LATCH:          nxt = S_FETCH_ADDR;
      default:          nxt = state;
    endcase
  end
  // datapath: PC, opcode/immediate latches, ALU result and register/flag write-back
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      counter_out <= ROM_BASE;
      opcode <= 8'h00;
      a_out <= 8'h00;
      b_out <= 8'h00;
      temp_1_out <= 8'h00;
      opnd <= 8'h00;
      res <= 9'h000;
      step <= 1'b0;
      flag_zero_o <= 1'b0;
      flag_negative_o <= 1'b0;
      flag_carry_o <= 1'b0;
    end else begin
      case (state)
        S_FETCH_LATCH: begin
          opcode <= data;
          counter_out <= counter_out + 16'd1;
        end
        S_OP_LATCH: begin
          temp_1_out <= data;
          counter_out <= counter_out + 16'd1;
        end
        S_EXEC: begin
          step <= is_alu & ~step;
          if (!is_alu) res <= {1'b0, temp_1_out};
          else if (!step) opnd <= b_out;
          else res <= is_sub ? {1'b0, a_out} - {1'b0, opnd} : {1'b0, a_out} + {1'b0, opnd};
        end
        S_LATCH: begin
          if (opcode == LDI_A || opcode == ADD_B || opcode == SUB_B) a_out <= res[7:0];
          if (opcode == LDI_B) b_out <= res[7:0];
          if (is_ldi || is_alu) begin
            flag_zero_o <= res[7:0] == 8'h00;
            flag_negative_o <= res[7];
            flag_carry_o <= is_sub ? ~res[8] : res[8];
          end
        end
        default: ;
      endcase
    end
endmodule

module sap2_computer #(
  parameter logic [15:0] ROM_BASE  = 16'hF000,
  parameter int          ROM_DEPTH = 4096,
  parameter int          RAM_DEPTH = 4096
) (
  input  logic clk,
  input  logic reset,
  output logic halt
);
  logic [15:0] addr, off;
  logic [7:0] data, rom_q, ram_q;
  logic rd, rom_sel, ram_sel;
  assign off = addr - ROM_BASE;
  assign data = rom_sel ? rom_q : ram_sel ? ram_q : 8'h00;
  // remember which memory the pending read targets; unmapped space reads as NOP
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rom_sel <= 1'b0;
      ram_sel <= 1'b0;
    end else if (rd) begin
      rom_sel <= addr >= ROM_BASE && {16'h0000, off} < ROM_DEPTH;
      ram_sel <= {16'h0000, addr} < RAM_DEPTH;
    end
  sap2_cpu #(.ROM_BASE(ROM_BASE)) u_cpu (
    .clk(clk), .reset(reset), .data(data), .addr(addr), .rd(rd), .halt(halt),
    .flag_zero_o(), .flag_negative_o(), .flag_carry_o()
  );
  sap2_rom #(.DEPTH(ROM_DEPTH)) u_rom (
    .clk(clk), .rd(rd), .addr(off[$clog2(ROM_DEPTH)-1:0]), .q(rom_q)
  );
  sap2_ram #(.DEPTH(RAM_DEPTH)) u_ram (
    .clk(clk), .rd(rd), .addr(addr[$clog2(RAM_DEPTH)-1:0]), .q(ram_q)
  );
endmodule

// File: tb/tb_sap2_computer.sv
// tb_sap2_computer: scoreboard bench running directed programs on the SAP-2 machine
module tb_sap2_computer;
  import arch_defs_pkg::*;
  typedef struct {
    string       tag;
    int          cyc;
    logic [7:0]  a, b;
    logic        z, n, c;
    logic [15:0] pc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic halt;
  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];
  logic [7:0] m_a, m_b;
  logic m_z, m_n, m_c;
  logic [15:0] wp;
  sap2_computer dut (.clk(clk), .reset(reset), .halt(halt));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_a = 8'h00; m_b = 8'h00; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; wp = 16'hF000;
  endtask
  task automatic wr(input logic [7:0] v);
    dut.u_rom.mem[int'(wp - 16'hF000)] = v;
    wp = wp + 16'd1;
  endtask
  task automatic put(input logic [7:0] op, input logic [7:0] imm);
    exp_t e;
    logic [8:0] r;
    e.tag = $sformatf("op%02h@%04h", op, wp);
    wr(op);
    e.cyc = 6;
    if (op == LDI_A || op == LDI_B) begin
      wr(imm);
      e.cyc = 10;
      if (op == LDI_A) m_a = imm; else m_b = imm;
      m_z = imm == 8'h00; m_n = imm[7]; m_c = 1'b0;
    end else if (op == ADD_B) begin
      r = {1'b0, m_a} + {1'b0, m_b};
      e.cyc = 7;
      m_c = r[8]; m_a = r[7:0]; m_z = m_a == 8'h00; m_n = m_a[7];
    end else if (op == SUB_B || op == CMP_B) begin
      r = {1'b0, m_a} - {1'b0, m_b};
      e.cyc = 7;
      m_c = m_a >= m_b; m_z = r[7:0] == 8'h00; m_n = r[7];
      if (op == SUB_B) m_a = r[7:0];
    end
    e.a = m_a; e.b = m_b; e.z = m_z; e.n = m_n; e.c = m_c; e.pc = wp;
    sb.push_back(e);
  endtask
  task automatic check_regs(input string tag, input exp_t e);
    check({tag, ".a"}, 16'(dut.u_cpu.a_out), 16'(e.a));
    check({tag, ".b"}, 16'(dut.u_cpu.b_out), 16'(e.b));
    check({tag, ".z"}, 16'(dut.u_cpu.flag_zero_o), 16'(e.z));
    check({tag, ".n"}, 16'(dut.u_cpu.flag_negative_o), 16'(e.n));
    check({tag, ".c"}, 16'(dut.u_cpu.flag_carry_o), 16'(e.c));
    check({tag, ".pc"}, dut.u_cpu.counter_out, e.pc);
  endtask
  task automatic drain(input int keep, input bit probe);
    exp_t e;
    while (sb.size() > keep) begin
      e = sb.pop_front();
      if (probe) begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("opcode_c5", 16'(dut.u_cpu.opcode), 16'(LDI_A));
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("temp_c9", 16'(dut.u_cpu.temp_1_out), 16'h0001);
        repeat (e.cyc - 8) @(posedge clk);
        probe = 1'b0;
      end else repeat (e.cyc) @(posedge clk);
      @(negedge clk);
      check_regs(e.tag, e);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, ".pc"}, dut.u_cpu.counter_out, 16'hF000);
    check({tag, ".a"}, 16'(dut.u_cpu.a_out), 16'h0000);
    check({tag, ".b"}, 16'(dut.u_cpu.b_out), 16'h0000);
    check({tag, ".op"}, 16'(dut.u_cpu.opcode), 16'h0000);
    check({tag, ".flags"}, 16'({dut.u_cpu.flag_zero_o, dut.u_cpu.flag_negative_o, dut.u_cpu.flag_carry_o}), 16'h0000);
    check({tag, ".halt"}, 16'(halt), 16'h0000);
  endtask
  initial begin
    dut.u_rom.init_sim_rom();
    dut.u_ram.init_sim_ram();
    model_reset();
    put(LDI_A, 8'h01);
    put(LDI_B, 8'h03);
    put(CMP_B, 8'h00);
    put(LDI_B, 8'h00);
    put(CMP_B, 8'h00);
    wr(HLT);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    reset = 1'b0;
    drain(0, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("hlt.op", 16'(dut.u_cpu.opcode), 16'(HLT));
    check("hlt.pc", dut.u_cpu.counter_out, 16'hF009);
    check("hlt.halt", 16'(halt), 16'h0001);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("hold.pc", dut.u_cpu.counter_out, 16'hF009);
    check("hold.halt", 16'(halt), 16'h0001);
    check("hold.a", 16'(dut.u_cpu.a_out), 16'h0001);
    check("hold.b", 16'(dut.u_cpu.b_out), 16'h0000);
    reset = 1'b1;
    dut.u_rom.init_sim_rom();
    model_reset();
    put(LDI_A, 8'hFF);
    put(LDI_B, 8'h01);
    put(ADD_B, 8'h00);
    put(SUB_B, 8'h00);
    put(NOP, 8'h00);
    put(8'h77, 8'h00);
    put(LDI_B, 8'h03);
    put(CMP_B, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    drain(1, 1'b0);
    void'(sb.pop_front());
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset("midrst");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    put(LDI_A, 8'hFF);
    put(LDI_B, 8'h01);
    drain(0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
